// File: rtl/ysyx_22050598_cache_miss_ctrl.sv
// D-cache miss sequencer: picks the LRU victim, writes it back when dirty, refills the line,
// and records the refilled way. Shares the single LRU write port with hit-path touches.
module ysyx_22050598_cache_miss_ctrl #(
    parameter int unsigned SET_W = 6,
    parameter int unsigned WAY_W = 2,
    parameter int unsigned TAG_W = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss_valid,
    output logic             miss_ready,
    input  logic [SET_W-1:0] miss_set,
    input  logic [TAG_W-1:0] miss_tag,
    output logic             miss_done,
    output logic [WAY_W-1:0] miss_way,
    input  logic             hit_valid,
    output logic             hit_ready,
    input  logic [SET_W-1:0] hit_set,
    input  logic [WAY_W-1:0] hit_way,
    output logic             lru_wen,
    output logic [SET_W-1:0] lru_set_index,
    output logic [WAY_W-1:0] lru_way_i,
    input  logic [WAY_W-1:0] lru_way_o,
    output logic [SET_W-1:0] vic_set,
    output logic [WAY_W-1:0] vic_way,
    input  logic             vic_valid,
    input  logic             vic_dirty,
    input  logic [TAG_W-1:0] vic_tag,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    input  logic             wb_done,
    output logic             rf_valid,
    input  logic             rf_ready,
    output logic [TAG_W-1:0] rf_tag,
    input  logic             rf_done,
    output logic             busy
);
    typedef enum logic [2:0] {
        StIdle, StVictim, StWbReq, StWbWait, StRfReq, StRfWait, StUpdate
    } state_e;

    state_e           state_q, state_d;
    logic [SET_W-1:0] set_q, set_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WAY_W-1:0] way_q, way_d;
    logic [TAG_W-1:0] vtag_q, vtag_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            set_q   <= '0;
            tag_q   <= '0;
            way_q   <= '0;
            vtag_q  <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            tag_q   <= tag_d;
            way_q   <= way_d;
            vtag_q  <= vtag_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        set_d         = set_q;
        tag_d         = tag_q;
        way_d         = way_q;
        vtag_d        = vtag_q;
        miss_ready    = 1'b0;
        miss_done     = 1'b0;
        wb_valid      = 1'b0;
        rf_valid      = 1'b0;
        lru_wen       = 1'b0;
        lru_set_index = hit_set;
        lru_way_i     = hit_way;
        // VICTIM and UPDATE own the LRU port; hits stall there.
        hit_ready     = !rst && (state_q != StVictim) && (state_q != StUpdate);

        unique case (state_q)
            StIdle: begin
                miss_ready = !rst;
                if (miss_valid) begin
                    set_d   = miss_set;
                    tag_d   = miss_tag;
                    state_d = StVictim;
                end
            end
            StVictim: begin
                lru_set_index = set_q;
                way_d         = lru_way_o;
                vtag_d        = vic_tag;
                state_d       = (vic_valid && vic_dirty) ? StWbReq : StRfReq;
            end
            StWbReq: begin
                wb_valid = 1'b1;
                if (wb_ready) state_d = StWbWait;
            end
            StWbWait: begin
                if (wb_done) state_d = StRfReq;
            end
            StRfReq: begin
                rf_valid = 1'b1;
                if (rf_ready) state_d = StRfWait;
            end
            StRfWait: begin
                if (rf_done) state_d = StUpdate;
            end
            StUpdate: begin
                lru_wen       = 1'b1;
                lru_set_index = set_q;
                lru_way_i     = way_q;
                miss_done     = 1'b1;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (hit_valid && hit_ready) begin
            lru_wen       = 1'b1;
            lru_set_index = hit_set;
            lru_way_i     = hit_way;
        end
    end

    assign vic_set  = set_q;
    assign vic_way  = lru_way_o;
    assign miss_way = way_q;
    assign wb_tag   = vtag_q;
    assign rf_tag   = tag_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ysyx_22050598_cache_miss_ctrl.sv
// Bench for the miss sequencer: models the LRU/tag arrays and memory side, checks every cycle
// of each miss against expectations derived from a transaction-level LRU reference.
module tb_ysyx_22050598_cache_miss_ctrl;
    logic        clk, rst;
    logic        miss_valid, miss_ready, miss_done;
    logic [5:0]  miss_set;
    logic [20:0] miss_tag;
    logic [1:0]  miss_way;
    logic        hit_valid, hit_ready;
    logic [5:0]  hit_set;
    logic [1:0]  hit_way;
    logic        lru_wen;
    logic [5:0]  lru_set_index;
    logic [1:0]  lru_way_i, lru_way_o;
    logic [5:0]  vic_set;
    logic [1:0]  vic_way;
    logic        vic_valid, vic_dirty;
    logic [20:0] vic_tag;
    logic        wb_valid, wb_ready, wb_done;
    logic [20:0] wb_tag;
    logic        rf_valid, rf_ready, rf_done;
    logic [20:0] rf_tag;
    logic        busy;

    ysyx_22050598_cache_miss_ctrl dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_set(miss_set),
        .miss_tag(miss_tag), .miss_done(miss_done), .miss_way(miss_way),
        .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_set(hit_set), .hit_way(hit_way),
        .lru_wen(lru_wen), .lru_set_index(lru_set_index), .lru_way_i(lru_way_i),
        .lru_way_o(lru_way_o), .vic_set(vic_set), .vic_way(vic_way), .vic_valid(vic_valid),
        .vic_dirty(vic_dirty), .vic_tag(vic_tag), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_tag(wb_tag), .wb_done(wb_done), .rf_valid(rf_valid), .rf_ready(rf_ready),
        .rf_tag(rf_tag), .rf_done(rf_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment LRU array: victim is the way after the most recently touched one.
    logic [1:0] env_last [64] = '{default: 2'd0};
    logic       pre_en = 1'b0;
    logic [5:0] pre_set = '0;
    logic [1:0] pre_val = '0;
    always @(posedge clk) begin
        if (pre_en) env_last[pre_set] <= pre_val;
        else if (lru_wen) env_last[lru_set_index] <= lru_way_i;
    end
    assign lru_way_o = env_last[lru_set_index] + 2'd1;

    // Environment tag array, written only by the stimulus process.
    bit          tv [64][4];
    bit          td [64][4];
    logic [20:0] tt [64][4];
    assign vic_valid = tv[vic_set][vic_way];
    assign vic_dirty = td[vic_set][vic_way];
    assign vic_tag   = tt[vic_set][vic_way];

    // Reference: last touched way per set, updated from accepted hits and completed misses.
    int ref_last [64];
    int errors = 0;
    int checks = 0;

    bit         pend;
    logic [5:0] ph_set;
    logic [1:0] ph_way;

    typedef struct {
        logic [5:0]  vset;
        logic [20:0] tag;
        logic [1:0]  last;
        bit          vv;
        bit          vd;
        logic [20:0] vtag;
        int          wb_hold;
        int          rf_hold;
        int          exp_way;
        int          exp_wb;
    } vec_t;
    vec_t tbl [5];

    function automatic int ref_victim(input logic [5:0] s);
        return (ref_last[s] + 1) % 4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic hit_drive();
        hit_valid = pend;
        hit_set   = ph_set;
        hit_way   = ph_way;
    endtask

    task automatic hit_check(input bit owned);
        chk("hit_ready", hit_ready, owned ? 0 : 1);
        if (!owned) begin
            chk("lru_wen_hit", lru_wen, pend);
            if (pend) begin
                chk("lru_set_hit", lru_set_index, ph_set);
                chk("lru_way_hit", lru_way_i, ph_way);
                ref_last[ph_set] = ph_way;
                pend = 1'b0;
            end
        end
    endtask

    task automatic set_lru(input logic [5:0] s, input logic [1:0] l);
        pre_en  = 1'b1;
        pre_set = s;
        pre_val = l;
        cyc();
        pre_en  = 1'b0;
        ref_last[s] = l;
    endtask

    task automatic idle_tick();
        cyc();
        hit_drive();
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_miss_ready", miss_ready, 1);
        chk("idle_miss_done", miss_done, 0);
        chk("idle_wb_valid", wb_valid, 0);
        chk("idle_rf_valid", rf_valid, 0);
        hit_check(0);
    endtask

    task automatic do_miss(input logic [5:0] s, input logic [20:0] t, input int exp_way,
                           input int exp_wb, input int wb_hold, input int wb_wait,
                           input int rf_hold, input int rf_wait, input bit rnd_hits,
                           input bit stall);
        int          v;
        bit          wbx;
        logic [20:0] vt;
        cyc();
        miss_valid = 1'b1;
        miss_set   = s;
        miss_tag   = t;
        hit_drive();
        #1;
        chk("accept_ready", miss_ready, 1);
        chk("accept_busy", busy, 0);
        chk("accept_done", miss_done, 0);
        hit_check(0);
        if (exp_way >= 0) begin
            v   = exp_way;
            wbx = (exp_wb != 0);
        end else begin
            v   = ref_victim(s);
            wbx = tv[s][v] && td[s][v];
        end
        vt = tt[s][v];

        cyc();
        miss_valid = 1'b0;
        if (stall) begin
            pend = 1'b1; ph_set = 6'h21; ph_way = 2'd1;
        end
        hit_drive();
        #1;
        chk("victim_busy", busy, 1);
        chk("victim_miss_ready", miss_ready, 0);
        chk("victim_lru_set", lru_set_index, s);
        chk("victim_vic_set", vic_set, s);
        chk("victim_vic_way", vic_way, v);
        chk("victim_lru_wen", lru_wen, 0);
        chk("victim_wb_valid", wb_valid, 0);
        chk("victim_rf_valid", rf_valid, 0);
        hit_check(1);

        if (wbx) begin
            for (int i = 0; i <= wb_hold; i++) begin
                cyc();
                wb_ready = (i == wb_hold);
                wb_done  = (i == 0 && wb_hold > 0); // early done must be ignored
                hit_drive();
                #1;
                chk("wbreq_wb_valid", wb_valid, 1);
                chk("wbreq_wb_tag", wb_tag, vt);
                chk("wbreq_rf_valid", rf_valid, 0);
                hit_check(0);
            end
            for (int i = 0; i <= wb_wait; i++) begin
                cyc();
                wb_ready = 1'b0;
                wb_done  = (i == wb_wait);
                hit_drive();
                #1;
                chk("wbwait_wb_valid", wb_valid, 0);
                chk("wbwait_rf_valid", rf_valid, 0);
                chk("wbwait_busy", busy, 1);
                hit_check(0);
            end
        end

        for (int i = 0; i <= rf_hold; i++) begin
            cyc();
            wb_done  = 1'b0;
            rf_ready = (i == rf_hold);
            hit_drive();
            #1;
            chk("rfreq_rf_valid", rf_valid, 1);
            chk("rfreq_rf_tag", rf_tag, t);
            chk("rfreq_wb_valid", wb_valid, 0);
            hit_check(0);
        end

        for (int i = 0; i <= rf_wait; i++) begin
            cyc();
            rf_ready = 1'b0;
            rf_done  = (i == rf_wait);
            if (rnd_hits && $urandom_range(0, 1) == 1) begin
                pend = 1'b1; ph_set = 6'($urandom); ph_way = 2'($urandom);
            end
            hit_drive();
            #1;
            chk("rfwait_rf_valid", rf_valid, 0);
            chk("rfwait_wb_valid", wb_valid, 0);
            chk("rfwait_miss_done", miss_done, 0);
            hit_check(0);
        end

        cyc();
        rf_done = 1'b0;
        if (stall) begin
            pend = 1'b1; ph_set = 6'h0C; ph_way = 2'd2;
        end
        hit_drive();
        #1;
        chk("update_miss_done", miss_done, 1);
        chk("update_miss_way", miss_way, v);
        chk("update_lru_wen", lru_wen, 1);
        chk("update_lru_set", lru_set_index, s);
        chk("update_lru_way", lru_way_i, v);
        chk("update_miss_ready", miss_ready, 0);
        hit_check(1);
        ref_last[s] = v;
        tv[s][v] = 1'b1;
        td[s][v] = 1'b0;
        tt[s][v] = t;
    endtask

    initial begin
        logic [5:0]  rs;
        logic [20:0] rt;
        rst = 1'b1;
        miss_valid = 0; miss_set = '0; miss_tag = '0;
        hit_valid = 0; hit_set = '0; hit_way = '0;
        wb_ready = 0; wb_done = 0; rf_ready = 0; rf_done = 0;
        pend = 0; ph_set = '0; ph_way = '0;
        for (int i = 0; i < 64; i++) begin
            ref_last[i] = 0;
            for (int w = 0; w < 4; w++) begin
                tv[i][w] = 0; td[i][w] = 0; tt[i][w] = '0;
            end
        end

        tbl[0] = '{6'h05, 21'h0AAAA, 2'd1, 1'b0, 1'b0, 21'h0, 0, 1, 2, 0};
        tbl[1] = '{6'h3F, 21'h12345, 2'd0, 1'b1, 1'b1, 21'h1ABCD, 3, 0, 1, 1};
        tbl[2] = '{6'h00, 21'h1FFFFF, 2'd3, 1'b1, 1'b0, 21'h00F0F, 0, 2, 0, 0};
        tbl[3] = '{6'h2A, 21'h00000, 2'd2, 1'b0, 1'b1, 21'h15555, 0, 0, 3, 0};
        tbl[4] = '{6'h11, 21'h0BEEF, 2'd0, 1'b1, 1'b1, 21'h00001, 0, 1, 1, 1};

        // Reset state; a hit presented during reset must not be accepted.
        cyc();
        hit_valid = 1'b1;
        #1;
        chk("rst_miss_ready", miss_ready, 0);
        chk("rst_hit_ready", hit_ready, 0);
        chk("rst_lru_wen", lru_wen, 0);
        cyc();
        rst = 1'b0;
        hit_valid = 1'b0;
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_miss_ready", miss_ready, 1);
        chk("post_rst_hit_ready", hit_ready, 1);
        chk("post_rst_wb_valid", wb_valid, 0);
        chk("post_rst_rf_valid", rf_valid, 0);
        chk("post_rst_lru_wen", lru_wen, 0);
        chk("post_rst_miss_done", miss_done, 0);
        chk("post_rst_wb_tag", wb_tag, 0);
        chk("post_rst_rf_tag", rf_tag, 0);
        chk("post_rst_miss_way", miss_way, 0);

        foreach (tbl[k]) begin
            set_lru(tbl[k].vset, tbl[k].last);
            tv[tbl[k].vset][tbl[k].exp_way] = tbl[k].vv;
            td[tbl[k].vset][tbl[k].exp_way] = tbl[k].vd;
            tt[tbl[k].vset][tbl[k].exp_way] = tbl[k].vtag;
            do_miss(tbl[k].vset, tbl[k].tag, tbl[k].exp_way, tbl[k].exp_wb,
                    tbl[k].wb_hold, 1, tbl[k].rf_hold, 2, 1'b0, 1'b0);
            idle_tick();
        end

        // Hit and miss to set 7 together: victim must reflect the hit (way 3 -> victim 0).
        set_lru(6'h07, 2'd0);
        tv[7][0] = 1'b0;
        pend = 1'b1; ph_set = 6'h07; ph_way = 2'd3;
        do_miss(6'h07, 21'h00777, 0, 0, 0, 0, 0, 1, 1'b0, 1'b0);
        idle_tick();

        // Hits stalled in VICTIM and UPDATE, random hits while refilling.
        do_miss(6'h15, 21'h0C0DE, -1, 0, 2, 1, 1, 3, 1'b1, 1'b1);
        idle_tick();

        // Reset while waiting for the write-back; the late wb_done must be ignored.
        set_lru(6'h10, 2'd0);
        tv[16][1] = 1'b1; td[16][1] = 1'b1; tt[16][1] = 21'h0F00D;
        cyc(); miss_valid = 1'b1; miss_set = 6'h10; miss_tag = 21'h02222; #1;
        chk("rstwb_accept", miss_ready, 1);
        cyc(); miss_valid = 1'b0; #1;
        chk("rstwb_victim_busy", busy, 1);
        cyc(); wb_ready = 1'b1; #1;
        chk("rstwb_wb_valid", wb_valid, 1);
        cyc(); wb_ready = 1'b0; #1;
        chk("rstwb_wait_wb_valid", wb_valid, 0);
        chk("rstwb_wait_busy", busy, 1);
        cyc(); rst = 1'b1; #1;
        chk("rstwb_rst_miss_ready", miss_ready, 0);
        chk("rstwb_rst_hit_ready", hit_ready, 0);
        cyc(); rst = 1'b0; #1;
        chk("rstwb_busy", busy, 0);
        chk("rstwb_wb_valid_after", wb_valid, 0);
        chk("rstwb_rf_valid_after", rf_valid, 0);
        chk("rstwb_wb_tag", wb_tag, 0);
        chk("rstwb_miss_ready", miss_ready, 1);
        cyc(); wb_done = 1'b1; #1;
        chk("rstwb_late_done_busy", busy, 0);
        cyc(); wb_done = 1'b0; #1;
        chk("rstwb_late_done_rf", rf_valid, 0);
        chk("rstwb_late_done_busy2", busy, 0);
        do_miss(6'h10, 21'h03333, 1, 1, 1, 0, 0, 0, 1'b0, 1'b0);

        // Back-to-back misses with no idle gap between them.
        do_miss(6'h22, 21'h04444, -1, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        do_miss(6'h23, 21'h05555, -1, 0, 0, 0, 1, 1, 1'b0, 1'b0);

        // Randomised misses against the reference LRU and tag contents.
        for (int n = 0; n < 40; n++) begin
            rs = 6'($urandom);
            rt = 21'($urandom);
            for (int w = 0; w < 4; w++) begin
                tv[rs][w] = 1'($urandom);
                td[rs][w] = 1'($urandom);
                tt[rs][w] = 21'($urandom);
            end
            do_miss(rs, rt, -1, 0, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 4), 1'b1,
                    $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) idle_tick();
        end
        idle_tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
